// File: rtl/rotary_decoder.sv
// rotary_decoder: quadrature rotary encoder + push switch decoder with a small event queue.
//   Raw A/B/C inputs are synchronized and debounced. Filtered {A,B} drives a
//   quadrature tracker that emits one CW/CCW event per full detent, and a
//   filtered C rising edge emits a press event. Events go through a 1-entry
//   pending slot into a FIFO that the CPU drains with a valid/pop handshake.
//   A wrapping signed detent count is kept alongside.
// Optional feature: define ROT_ACCEL_EN to add ACCEL_WINDOW and position
//   acceleration (+/-4 per detent on fast same-direction turning).
// Ports:
//   Clock, Reset          clock, asynchronous active-low reset
//   iRotA, iRotB          raw quadrature phases
//   iRotCenter            raw push switch, 1 = pressed
//   iPop                  consume head event (ignored when empty)
//   iClearOverflow        clear the sticky overflow flag
//   oEventValid, oEvent   FIFO head: 01 CW, 10 CCW, 11 press, 00 empty
//   oPosition             signed wrapping detent count
//   oOverflow             sticky: an event was dropped
module rotary_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 5000,
    parameter int unsigned CNT_WIDTH       = 8,
    parameter int unsigned FIFO_DEPTH      = 4
`ifdef ROT_ACCEL_EN
    ,
    parameter int unsigned ACCEL_WINDOW    = 2_500_000
`endif
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iRotA,
    input  logic                 iRotB,
    input  logic                 iRotCenter,
    input  logic                 iPop,
    input  logic                 iClearOverflow,
    output logic                 oEventValid,
    output logic [1:0]           oEvent,
    output logic [CNT_WIDTH-1:0] oPosition,
    output logic                 oOverflow
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_CW    = 2'b01,
        EV_CCW   = 2'b10,
        EV_PRESS = 2'b11
    } ev_e;

    // State encoding equals the filtered {A,B} value it represents.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_e;

    // Next state in the clockwise direction.
    function automatic quad_e cw_next(input quad_e s);
        case (s)
            S00:     cw_next = S01;
            S01:     cw_next = S11;
            S11:     cw_next = S10;
            default: cw_next = S00;
        endcase
    endfunction

    // Bit 0 = A, bit 1 = B, bit 2 = C
    logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    quad_e                 state_q, state_d, ab_c;
    logic [2:0]            acc_q, acc_d;          // two's complement step count
    logic [3:0]            acc_sum_c;
    logic                  illegal_c;
    ev_e                   rot_ev_q, rot_ev_d;
    logic                  press_q, press_d, c_prev_q, c_prev_d;
    logic [CNT_WIDTH-1:0]  pos_q, pos_d, step_c;
    ev_e                   pend_q, pend_d, push_data_c;
    logic                  push_c, drop_c, do_pop_c, do_push_c;
    logic [FIFO_DEPTH-1:0][1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d, ovf_q, ovf_d;
    ev_e                   event_q, event_d;

    // Two-flop synchronizers and per-input debounce counters
    always_comb begin
        sync1_d  = {iRotCenter, iRotB, iRotA};
        sync2_d  = sync1_q;
        filt_d   = filt_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    filt_d[i]   = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    // Quadrature tracker and press edge detect; events are registered
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rot_ev_d  = EV_NONE;
        acc_sum_c = {acc_q[2], acc_q};
        illegal_c = 1'b0;
        ab_c      = quad_e'({filt_q[0], filt_q[1]});
        press_d   = filt_q[2] & ~c_prev_q;
        c_prev_d  = filt_q[2];
        if (ab_c != state_q) begin
            state_d = ab_c;
            if (ab_c == cw_next(state_q)) begin
                acc_sum_c = {acc_q[2], acc_q} + 4'd1;
            end else if (cw_next(ab_c) == state_q) begin
                acc_sum_c = {acc_q[2], acc_q} - 4'd1;
            end else begin
                acc_sum_c = 4'd0;
                illegal_c = 1'b1;
            end
            acc_d = acc_sum_c[2:0];
            // A full cycle back to S00 is +4 (CW) or -4 (CCW)
            if (ab_c == S00) begin
                acc_d = 3'd0;
                if (!illegal_c && acc_sum_c == 4'b0100) begin
                    rot_ev_d = EV_CW;
                end else if (!illegal_c && acc_sum_c == 4'b1100) begin
                    rot_ev_d = EV_CCW;
                end
            end
        end
    end

`ifdef ROT_ACCEL_EN
    localparam int unsigned TMR_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ACCEL_WINDOW);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    ev_e              last_dir_q, last_dir_d;

    // Cycles since last detent; fast same-direction turning steps by 4
    always_comb begin
        step_c     = CNT_WIDTH'(1);
        tmr_d      = tmr_q;
        last_dir_d = last_dir_q;
        if (tmr_q < TMR_MAX) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        if (rot_ev_d != EV_NONE) begin
            if (rot_ev_d == last_dir_q && tmr_q < TMR_MAX) begin
                step_c = CNT_WIDTH'(4);
            end
            tmr_d      = '0;
            last_dir_d = rot_ev_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tmr_q      <= '0;
            last_dir_q <= EV_NONE;
        end else begin
            tmr_q      <= tmr_d;
            last_dir_q <= last_dir_d;
        end
    end
`else
    assign step_c = CNT_WIDTH'(1);
`endif

    // Position counts every detent, whether or not its event is queued
    always_comb begin
        pos_d = pos_q;
        if (rot_ev_d == EV_CW) begin
            pos_d = pos_q + step_c;
        end else if (rot_ev_d == EV_CCW) begin
            pos_d = pos_q - step_c;
        end
    end

    // Pending slot arbitration, FIFO update and registered head outputs
    always_comb begin
        push_c      = 1'b0;
        push_data_c = EV_NONE;
        pend_d      = pend_q;
        drop_c      = 1'b0;
        if (pend_q != EV_NONE) begin
            push_c      = 1'b1;
            push_data_c = pend_q;
            pend_d      = EV_NONE;
            drop_c      = press_q || (rot_ev_q != EV_NONE);
        end else if (press_q) begin
            push_c      = 1'b1;
            push_data_c = EV_PRESS;
            pend_d      = rot_ev_q;
        end else if (rot_ev_q != EV_NONE) begin
            push_c      = 1'b1;
            push_data_c = rot_ev_q;
        end

        do_pop_c  = iPop && (cnt_q != '0);
        do_push_c = push_c && ((cnt_q != CNT_W'(FIFO_DEPTH)) || do_pop_c);
        if (push_c && !do_push_c) begin
            drop_c = 1'b1;
        end

        mem_d = mem_q;
        if (do_push_c) begin
            mem_d[wr_q] = push_data_c;
        end
        wr_d    = wr_q + PTR_W'(do_push_c);
        rd_d    = rd_q + PTR_W'(do_pop_c);
        cnt_d   = cnt_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        valid_d = (cnt_d != '0);
        event_d = valid_d ? ev_e'(mem_d[rd_d]) : EV_NONE;
        // Setting beats clearing
        ovf_d   = drop_c ? 1'b1 : (iClearOverflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            db_cnt_q <= '0;
            state_q  <= S00;
            acc_q    <= '0;
            rot_ev_q <= EV_NONE;
            press_q  <= 1'b0;
            c_prev_q <= 1'b0;
            pos_q    <= '0;
            pend_q   <= EV_NONE;
            mem_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            event_q  <= EV_NONE;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            acc_q    <= acc_d;
            rot_ev_q <= rot_ev_d;
            press_q  <= press_d;
            c_prev_q <= c_prev_d;
            pos_q    <= pos_d;
            pend_q   <= pend_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            event_q  <= event_d;
            ovf_q    <= ovf_d;
        end
    end

    assign oEventValid = valid_q;
    assign oEvent      = event_q;
    assign oPosition   = pos_q;
    assign oOverflow   = ovf_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder (DEBOUNCE_CYCLES=4, CNT_WIDTH=8, FIFO_DEPTH=4).
module tb_rotary_decoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iRotA = 1'b0;
    logic       iRotB = 1'b0;
    logic       iRotCenter = 1'b0;
    logic       iPop = 1'b0;
    logic       iClearOverflow = 1'b0;
    logic       oEventValid;
    logic [1:0] oEvent;
    logic [7:0] oPosition;
    logic       oOverflow;

    int n_cmp  = 0;
    int n_fail = 0;

    rotary_decoder #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (8),
        .FIFO_DEPTH     (4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iRotA         (iRotA),
        .iRotB         (iRotB),
        .iRotCenter    (iRotCenter),
        .iPop          (iPop),
        .iClearOverflow(iClearOverflow),
        .oEventValid   (oEventValid),
        .oEvent        (oEvent),
        .oPosition     (oPosition),
        .oOverflow     (oOverflow)
    );

    always #5 Clock = ~Clock;

    // Inputs change and outputs are sampled 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic set_ab(input logic a, input logic b, input int hold);
        iRotA = a;
        iRotB = b;
        tick(hold);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        iRotA = 1'b0; iRotB = 1'b0; iRotCenter = 1'b0;
        iPop = 1'b0; iClearOverflow = 1'b0;
        tick(3);
        Reset = 1'b1;
        tick(2);
    endtask

    task automatic pop();
        iPop = 1'b1;
        tick(1);
        iPop = 1'b0;
    endtask

    task automatic cw_detent();
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b1, 1'b1, 20);
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b0, 1'b0, 20);
    endtask

    task automatic ccw_detent();
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b1, 1'b1, 20);
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b0, 1'b0, 20);
    endtask

    task automatic test_reset();
        do_reset();
        tick(20);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", oEventValid); end
        n_cmp++; if (oEvent !== 2'b00) begin n_fail++; $display("FAIL reset_event: got %b want 00", oEvent); end
        n_cmp++; if (oPosition !== 8'h00) begin n_fail++; $display("FAIL reset_pos: got %h want 00", oPosition); end
        n_cmp++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", oOverflow); end
    endtask

    task automatic test_cw_latency();
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b1, 1'b1, 20);
        set_ab(1'b1, 1'b0, 20);
        set_ab(1'b0, 1'b0, 7);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL cw_early_valid: got %b want 0 at +7", oEventValid); end
        tick(1);
        n_cmp++; if (oEventValid !== 1'b1) begin n_fail++; $display("FAIL cw_valid_at_8: got %b want 1", oEventValid); end
        n_cmp++; if (oEvent !== 2'b01) begin n_fail++; $display("FAIL cw_event: got %b want 01", oEvent); end
        n_cmp++; if (oPosition !== 8'h01) begin n_fail++; $display("FAIL cw_pos: got %h want 01", oPosition); end
        pop();
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL cw_pop_valid: got %b want 0", oEventValid); end
        n_cmp++; if (oEvent !== 2'b00) begin n_fail++; $display("FAIL cw_pop_event: got %b want 00", oEvent); end
        pop();
        tick(2);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b want 0", oEventValid); end
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 3; g++) begin
            iRotA = 1'b1;
            tick(3);
            iRotA = 1'b0;
            tick(10);
        end
        tick(20);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", oEventValid); end
        n_cmp++; if (oPosition !== 8'h01) begin n_fail++; $display("FAIL glitch_pos: got %h want 01", oPosition); end
    endtask

    task automatic test_illegal();
        set_ab(1'b1, 1'b1, 20);
        set_ab(1'b0, 1'b0, 30);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL illegal_valid: got %b want 0", oEventValid); end
        n_cmp++; if (oPosition !== 8'h01) begin n_fail++; $display("FAIL illegal_pos: got %h want 01", oPosition); end
    endtask

    task automatic test_wrap();
        do_reset();
        ccw_detent();
        n_cmp++; if (oPosition !== 8'hFF) begin n_fail++; $display("FAIL wrap_ccw_pos: got %h want ff", oPosition); end
        n_cmp++; if (oEvent !== 2'b10) begin n_fail++; $display("FAIL wrap_ccw_event: got %b want 10", oEvent); end
        pop();
        cw_detent();
        n_cmp++; if (oPosition !== 8'h00) begin n_fail++; $display("FAIL wrap_cw_pos: got %h want 00", oPosition); end
        n_cmp++; if (oEvent !== 2'b01) begin n_fail++; $display("FAIL wrap_cw_event: got %b want 01", oEvent); end
        pop();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int d = 0; d < 6; d++) cw_detent();
        n_cmp++; if (oOverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", oOverflow); end
        n_cmp++; if (oPosition !== 8'h06) begin n_fail++; $display("FAIL ovf_pos: got %h want 06", oPosition); end
        iClearOverflow = 1'b1;
        tick(1);
        iClearOverflow = 1'b0;
        n_cmp++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", oOverflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (oEventValid !== 1'b1) begin n_fail++; $display("FAIL ovf_q%0d_valid: got %b want 1", i, oEventValid); end
            n_cmp++; if (oEvent !== 2'b01) begin n_fail++; $display("FAIL ovf_q%0d_event: got %b want 01", i, oEvent); end
            pop();
        end
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", oEventValid); end
    endtask

    task automatic test_press_and_detent();
        do_reset();
        set_ab(1'b0, 1'b1, 20);
        set_ab(1'b1, 1'b1, 20);
        set_ab(1'b1, 1'b0, 20);
        iRotA = 1'b0;
        iRotB = 1'b0;
        iRotCenter = 1'b1;
        tick(8);
        n_cmp++; if (oEventValid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b want 1", oEventValid); end
        n_cmp++; if (oEvent !== 2'b11) begin n_fail++; $display("FAIL press_first: got %b want 11", oEvent); end
        // Pop while the pending rotation is pushed into a one-entry queue
        pop();
        n_cmp++; if (oEventValid !== 1'b1) begin n_fail++; $display("FAIL press_pp_valid: got %b want 1", oEventValid); end
        n_cmp++; if (oEvent !== 2'b01) begin n_fail++; $display("FAIL press_second: got %b want 01", oEvent); end
        pop();
        iRotCenter = 1'b0;
        tick(20);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", oEventValid); end
        n_cmp++; if (oPosition !== 8'h01) begin n_fail++; $display("FAIL press_pos: got %h want 01", oPosition); end
    endtask

    task automatic test_async_reset();
        cw_detent();
        n_cmp++; if (oEventValid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 1", oEventValid); end
        set_ab(1'b0, 1'b1, 4);
        #3;
        Reset = 1'b0;
        #1;
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", oEventValid); end
        n_cmp++; if (oEvent !== 2'b00) begin n_fail++; $display("FAIL areset_event: got %b want 00", oEvent); end
        n_cmp++; if (oPosition !== 8'h00) begin n_fail++; $display("FAIL areset_pos: got %h want 00", oPosition); end
        n_cmp++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL areset_ovf: got %b want 0", oOverflow); end
        iRotB = 1'b0;
        tick(2);
        Reset = 1'b1;
        tick(20);
        n_cmp++; if (oEventValid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", oEventValid); end
    endtask

    initial begin
        test_reset();
        test_cw_latency();
        test_glitch();
        test_illegal();
        test_wrap();
        test_overflow();
        test_press_and_detent();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
